// File: rtl/vram_arbiter_pkg.sv
// rtl/vram_arbiter_pkg.sv - shared frame-buffer constants and arbiter types
package vram_arbiter_pkg;

  // Frame-buffer geometry: 160x120 pixels, RGB332
  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 19200;

  // RGB332 field widths (red 3, green 3, blue 2)
  localparam int RED_W   = 3;
  localparam int GREEN_W = 3;
  localparam int BLUE_W  = 2;

  // Value the clear engine writes to every pixel
  localparam logic [DATA_W-1:0] CLR_VAL = 8'h00;

  // Last address the clear engine touches
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - requester and RAM-side bundle of the video RAM arbiter
interface vram_arbiter_if;
  import vram_arbiter_pkg::*;

  // Display scanout reads
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;

  // Drawing writer handshake
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  // Clear engine control
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;

  // Single-port RAM side
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, clr_start, ram_rdata,
    output disp_data, disp_valid, wr_ready, clr_busy, clr_done,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  // Requester / RAM-model side
  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data, clr_start, ram_rdata,
    input  disp_data, disp_valid, wr_ready, clr_busy, clr_done,
           ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - fixed-priority video RAM arbiter: display > clear > writer
module vram_arbiter
  import vram_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  vram_arbiter_if.slave  bus
);

  arb_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_busy_q;
  logic              clr_done_q;

  logic              ram_en_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;

  // rd_pipe[0]: read op on the RAM bus, rd_pipe[1]: ram_rdata holds the word
  logic [1:0]        rd_pipe;
  logic              disp_valid_q;
  logic [DATA_W-1:0] disp_data_q;

  logic              wr_ready_c;

  // Writer may only go when nothing of higher priority wants this slot
  assign wr_ready_c = (state == ST_IDLE) & ~bus.disp_req & ~bus.clr_start;

  assign bus.wr_ready   = wr_ready_c;
  assign bus.clr_busy   = clr_busy_q;
  assign bus.clr_done   = clr_done_q;
  assign bus.ram_en     = ram_en_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_data  = disp_data_q;

  // Slot selection, clear FSM and registered RAM command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      clr_cnt     <= '0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      clr_done_q <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;

      if (bus.disp_req) begin
        ram_en_q   <= 1'b1;
        ram_addr_q <= bus.disp_addr;
      end else if (state == ST_CLEAR) begin
        ram_en_q    <= 1'b1;
        ram_we_q    <= 1'b1;
        ram_addr_q  <= clr_cnt;
        ram_wdata_q <= CLR_VAL;
      end else if (bus.wr_valid && wr_ready_c) begin
        ram_en_q    <= 1'b1;
        ram_we_q    <= 1'b1;
        ram_addr_q  <= bus.wr_addr;
        ram_wdata_q <= bus.wr_data;
      end

      case (state)
        ST_IDLE: begin
          if (bus.clr_start) begin
            state      <= ST_CLEAR;
            clr_cnt    <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // A display cycle steals the slot, so the counter waits
          if (!bus.disp_req) begin
            if (clr_cnt == CLR_LAST) begin
              state      <= ST_IDLE;
              clr_busy_q <= 1'b0;
              clr_done_q <= 1'b1;
            end else begin
              clr_cnt <= clr_cnt + ADDR_W'(1);
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Read-valid shift register and display data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe      <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      rd_pipe      <= {rd_pipe[0], bus.disp_req};
      disp_valid_q <= rd_pipe[1];
      if (rd_pipe[1]) begin
        disp_data_q <= bus.ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for the video RAM arbiter
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  vram_arbiter_if bus();

  vram_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port synchronous RAM
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end
  end

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] data;
  } sb_t;
  sb_t sb_q[$];

  int checks = 0;
  int errors = 0;

  logic              in_clear = 1'b0;
  logic [ADDR_W-1:0] exp_clr_addr = '0;
  logic [ADDR_W-1:0] first_bad = '0;
  int                clr_writes = 0;
  int                clr_bad = 0;
  int                rdy_bad = 0;
  int                done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected read response: valid three cycles after the request cycle
  task automatic push_rd(input logic [DATA_W-1:0] d);
    sb_t e;
    e.cyc  = cyc + 3;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Monitor: read scoreboard, clear-write tracking, handshake rules
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.disp_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_disp_valid: cycle %0d data %0h expected no valid", cyc, bus.disp_data);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          if (bus.disp_data !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL disp_read: got data %0h at cycle %0d expected %0h at cycle %0d",
                     bus.disp_data, cyc, e.data, e.cyc);
          end
        end
      end
      if (in_clear && bus.ram_en && bus.ram_we) begin
        if (bus.ram_addr !== exp_clr_addr || bus.ram_wdata !== CLR_VAL) begin
          if (clr_bad == 0) first_bad = bus.ram_addr;
          clr_bad++;
        end
        exp_clr_addr = exp_clr_addr + 1'b1;
        clr_writes++;
      end
      if (in_clear && bus.clr_busy && bus.wr_ready) rdy_bad++;
      if (bus.clr_done) done_cnt++;
    end
  end

  initial begin
    logic [DATA_W-1:0] seq_vals [4];
    logic restarted;
    seq_vals[0] = 8'h11; seq_vals[1] = 8'h22; seq_vals[2] = 8'h33; seq_vals[3] = 8'h44;

    bus.disp_req  = 1'b0;
    bus.disp_addr = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.clr_start = 1'b0;

    mem[16]     <= 8'hE3;
    mem[5]      <= 8'h66;
    mem[15'h7000] <= 8'hC5;
    for (int i = 0; i < 4; i++) mem[i] <= seq_vals[i];

    // Reset state
    repeat (3) step();
    chk("rst_ram_en",     32'(bus.ram_en),     32'h0);
    chk("rst_ram_we",     32'(bus.ram_we),     32'h0);
    chk("rst_ram_addr",   32'(bus.ram_addr),   32'h0);
    chk("rst_ram_wdata",  32'(bus.ram_wdata),  32'h0);
    chk("rst_disp_valid", 32'(bus.disp_valid), 32'h0);
    chk("rst_disp_data",  32'(bus.disp_data),  32'h0);
    chk("rst_clr_busy",   32'(bus.clr_busy),   32'h0);
    chk("rst_clr_done",   32'(bus.clr_done),   32'h0);
    rst_n = 1'b1;
    step();

    // Single read latency
    bus.disp_req = 1'b1; bus.disp_addr = 15'h0010; push_rd(8'hE3);
    step();
    bus.disp_req = 1'b0;
    repeat (6) step();

    // Back-to-back reads
    for (int i = 0; i < 4; i++) begin
      bus.disp_req = 1'b1; bus.disp_addr = ADDR_W'(i); push_rd(seq_vals[i]);
      step();
    end
    bus.disp_req = 1'b0;
    repeat (6) step();

    // Display beats writer; writer goes on the first free cycle; read-after-write
    bus.disp_req = 1'b1; bus.disp_addr = 15'h0005; push_rd(8'h66);
    bus.wr_valid = 1'b1; bus.wr_addr = 15'h0200; bus.wr_data = 8'h5A;
    @(negedge clk);
    chk("prio_wr_ready_low", 32'(bus.wr_ready), 32'h0);
    step();
    chk("prio_read_en",   32'(bus.ram_en),   32'h1);
    chk("prio_read_we",   32'(bus.ram_we),   32'h0);
    chk("prio_read_addr", 32'(bus.ram_addr), 32'h5);
    bus.disp_req = 1'b0;
    @(negedge clk);
    chk("prio_wr_ready_high", 32'(bus.wr_ready), 32'h1);
    step();
    chk("prio_wr_we",    32'(bus.ram_we),    32'h1);
    chk("prio_wr_addr",  32'(bus.ram_addr),  32'h200);
    chk("prio_wr_wdata", 32'(bus.ram_wdata), 32'h5A);
    bus.wr_valid = 1'b0;
    bus.disp_req = 1'b1; bus.disp_addr = 15'h0200; push_rd(8'h5A);
    step();
    bus.disp_req = 1'b0;
    repeat (6) step();

    // Reset in the middle of a clear aborts it
    exp_clr_addr = '0; clr_writes = 0; clr_bad = 0; done_cnt = 0; in_clear = 1'b1;
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    for (int k = 0; k < 500 && clr_writes < 101; k++) step();
    chk("abort_reached_100", 32'(clr_writes >= 101), 32'h1);
    rst_n = 1'b0;
    #1;
    in_clear = 1'b0;
    chk("abort_ram_en",   32'(bus.ram_en),   32'h0);
    chk("abort_ram_we",   32'(bus.ram_we),   32'h0);
    chk("abort_clr_busy", 32'(bus.clr_busy), 32'h0);
    chk("abort_clr_done", 32'(bus.clr_done), 32'h0);
    chk("abort_seq_ok",   32'(clr_bad),      32'h0);
    repeat (3) step();
    rst_n = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_addr = 15'h0400; bus.wr_data = 8'h99;
    #1;
    chk("abort_wr_ready", 32'(bus.wr_ready), 32'h1);
    step();
    bus.wr_valid = 1'b0;
    bus.disp_req = 1'b1; bus.disp_addr = 15'h0400; push_rd(8'h99);
    step();
    bus.disp_req = 1'b0;
    repeat (6) step();
    chk("abort_no_clr_done", 32'(done_cnt), 32'h0);

    // Clear racing a writer, display every 4th cycle, restart attempt at 500
    exp_clr_addr = '0; clr_writes = 0; clr_bad = 0; rdy_bad = 0; done_cnt = 0;
    in_clear = 1'b1;
    restarted = 1'b0;
    bus.clr_start = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_addr = 15'h0300; bus.wr_data = 8'h77;
    @(negedge clk);
    chk("clr_vs_wr_ready", 32'(bus.wr_ready), 32'h0);
    step();
    bus.clr_start = 1'b0;
    chk("clr_busy_set",     32'(bus.clr_busy), 32'h1);
    chk("clr_vs_wr_no_op",  32'(bus.ram_en),   32'h0);
    for (int k = 0; k < 30000; k++) begin
      bus.disp_req  = (k % 4 == 0);
      bus.disp_addr = 15'h7000;
      if (bus.disp_req) push_rd(8'hC5);
      bus.clr_start = (clr_writes >= 500) && !restarted;
      if (bus.clr_start) restarted = 1'b1;
      step();
      if (done_cnt != 0) break;
    end
    in_clear = 1'b0;
    bus.disp_req = 1'b0; bus.clr_start = 1'b0; bus.wr_valid = 1'b0;
    chk("clr_restart_issued", 32'(restarted),  32'h1);
    chk("clr_write_count",    32'(clr_writes), 32'd19200);
    if (clr_bad != 0)
      $display("FAIL clr_sequence: %0d bad writes, first at addr %0h, expected 0 bad", clr_bad, first_bad);
    chk("clr_sequence_bad", 32'(clr_bad), 32'h0);
    chk("clr_wr_ready_low", 32'(rdy_bad), 32'h0);
    repeat (8) step();
    chk("clr_done_once",  32'(done_cnt),     32'h1);
    chk("clr_busy_clear", 32'(bus.clr_busy), 32'h0);
    chk("sb_drained",     32'(sb_q.size()),  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
